// File: rtl/reg_dest_scoreboard_pkg.sv
// Shared constants, types and helpers for the register destination scoreboard.
// The scoreboard tracks which architectural registers have a write in flight
// so that decode can hold back instructions that would read or overwrite them.
package reg_dest_scoreboard_pkg;

  // Architectural register file geometry.
  localparam int NUM_REGS    = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 16;
  localparam int BUSY_W      = 6;

  // Register 0 is hard-wired and is never tracked.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // Counter step and saturation constants.
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = 16'd1;
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = 16'hFFFF;
  localparam logic [BUSY_W-1:0]      BUSY_ONE  = 6'd1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // Busy-count update selector: bit 1 = a bit is being set, bit 0 = cleared.
  typedef enum logic [1:0] {
    BUSY_HOLD = 2'b00,
    BUSY_DEC  = 2'b01,
    BUSY_INC  = 2'b10,
    BUSY_SWAP = 2'b11
  } busy_step_e;

  // One-hot mask for a register address; zero register and disabled
  // requests produce an empty mask so they can never touch tracking state.
  function automatic reg_mask_t reg_onehot(input reg_addr_t addr, input logic en);
    reg_mask_t mask;
    mask = '0;
    if (en && (addr != ZERO_REG)) begin
      mask[addr] = 1'b1;
    end else begin
      mask = '0;
    end
    return mask;
  endfunction

  // True when the address names a real (nonzero) register.
  function automatic logic reg_is_real(input reg_addr_t addr);
    return (addr != ZERO_REG);
  endfunction

endpackage

// File: rtl/reg_dest_scoreboard_hazard.sv
// Combinational RAW/WAW hazard detection against the pending-write mask.
// A register that is being written back in the current cycle is treated as
// already free, so a dependent instruction can issue in the same cycle as
// the write-back that resolves its hazard.
module sb_hazard_check
  import reg_dest_scoreboard_pkg::*;
(
  input  logic [NUM_REGS-1:0]   pending_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_dest_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic                  use_rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic                  use_rt_i,
  input  logic                  wr_i,
  input  logic [REG_ADDR_W-1:0] dest_i,
  output logic                  raw_o,
  output logic                  waw_o
);

  reg_mask_t eff_pending_s;
  logic      raw_rs_s;
  logic      raw_rt_s;

  // Pending mask as seen by hazard logic, with the same-cycle write-back removed.
  always_comb begin
    eff_pending_s = pending_i & ~reg_onehot(wb_dest_i, wb_valid_i);
  end

  // Source and destination compares against the bypassed pending mask.
  always_comb begin
    raw_rs_s = use_rs_i && reg_is_real(rs_i)   && eff_pending_s[rs_i];
    raw_rt_s = use_rt_i && reg_is_real(rt_i)   && eff_pending_s[rt_i];
    raw_o    = raw_rs_s || raw_rt_s;
    waw_o    = wr_i     && reg_is_real(dest_i) && eff_pending_s[dest_i];
  end

endmodule

// File: rtl/reg_dest_scoreboard.sv
// Register destination scoreboard: records outstanding register writes from
// issue until write-back, gates issue on RAW/WAW hazards, counts stall
// cycles and flags write-backs to registers that had nothing outstanding.
module reg_dest_scoreboard
  import reg_dest_scoreboard_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [REG_ADDR_W-1:0]  issue_rs,
  input  logic [REG_ADDR_W-1:0]  issue_rt,
  input  logic                   issue_use_rs,
  input  logic                   issue_use_rt,
  input  logic                   issue_wr,
  input  logic [REG_ADDR_W-1:0]  issue_dest,
  input  logic                   wb_valid,
  input  logic [REG_ADDR_W-1:0]  wb_dest,
  input  logic                   flush,
  output logic [NUM_REGS-1:0]    pending,
  output logic [BUSY_W-1:0]      busy_count,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   err_spurious
);

  // Architectural state.
  reg_mask_t               pending_q,  pending_d;
  logic [BUSY_W-1:0]       busy_q,     busy_d;
  logic [STALL_CNT_W-1:0]  stall_q,    stall_d;
  logic                    err_q,      err_d;

  // Per-cycle decode of the request/write-back traffic.
  logic       raw_s;
  logic       waw_s;
  logic       ready_s;
  logic       accept_s;
  logic       stall_s;
  reg_mask_t  set_mask_s;
  reg_mask_t  clr_mask_s;
  logic       spurious_s;
  busy_step_e busy_step_s;

  sb_hazard_check u_hazard (
    .pending_i  (pending_q),
    .wb_valid_i (wb_valid),
    .wb_dest_i  (wb_dest),
    .rs_i       (issue_rs),
    .use_rs_i   (issue_use_rs),
    .rt_i       (issue_rt),
    .use_rt_i   (issue_use_rt),
    .wr_i       (issue_wr),
    .dest_i     (issue_dest),
    .raw_o      (raw_s),
    .waw_o      (waw_s)
  );

  // Issue handshake: ready depends only on flush and hazards, never on valid.
  always_comb begin
    ready_s  = !flush && !raw_s && !waw_s;
    accept_s = issue_valid && ready_s;
    stall_s  = issue_valid && !ready_s;
  end

  // Masks of bits being set by an accepted write and cleared by write-back.
  always_comb begin
    set_mask_s = reg_onehot(issue_dest, accept_s && issue_wr);
    clr_mask_s = reg_onehot(wb_dest, wb_valid) & pending_q;
    spurious_s = wb_valid && reg_is_real(wb_dest) && !pending_q[wb_dest];
    busy_step_s = busy_step_e'({|set_mask_s, |clr_mask_s});
  end

  // Next pending mask and busy count; flush wins over any same-cycle traffic.
  // A same-cycle clear and set of one register nets to set, and the count
  // moves by at most one so it always tracks the population of the mask.
  always_comb begin
    pending_d = pending_q;
    busy_d    = busy_q;
    if (flush) begin
      pending_d = '0;
      busy_d    = '0;
    end else begin
      pending_d = (pending_q & ~clr_mask_s) | set_mask_s;
      case (busy_step_s)
        BUSY_INC:  busy_d = busy_q + BUSY_ONE;
        BUSY_DEC:  busy_d = busy_q - BUSY_ONE;
        BUSY_SWAP: busy_d = busy_q;
        BUSY_HOLD: busy_d = busy_q;
        default:   busy_d = busy_q;
      endcase
    end
  end

  // Saturating stall counter and sticky spurious write-back flag.
  always_comb begin
    stall_d = stall_q;
    err_d   = err_q || spurious_s;
    if (stall_s && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      busy_q    <= '0;
      stall_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
    end
  end

  assign issue_ready  = ready_s;
  assign pending      = pending_q;
  assign busy_count   = busy_q;
  assign stall_cycles = stall_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Directed bench for reg_dest_scoreboard. The driver applies one vector per
// cycle just after the rising edge and queues the values the DUT should show
// at the following falling edge; a monitor pops and compares them there.
module tb_reg_dest_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        issue_use_rs;
  logic        issue_use_rt;
  logic        issue_wr;
  logic [4:0]  issue_dest;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic        flush;
  logic [31:0] pending;
  logic [5:0]  busy_count;
  logic [15:0] stall_cycles;
  logic        err_spurious;

  reg_dest_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_use_rs (issue_use_rs),
    .issue_use_rt (issue_use_rt),
    .issue_wr     (issue_wr),
    .issue_dest   (issue_dest),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .flush        (flush),
    .pending      (pending),
    .busy_count   (busy_count),
    .stall_cycles (stall_cycles),
    .err_spurious (err_spurious)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic        rdy;
    logic [31:0] pend;
    logic [5:0]  busy;
    logic [15:0] stall;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation due at this falling edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: check missed, due cycle %0d now %0d", mon_e.name, mon_e.cyc, cyc);
      end else begin
        cmp(mon_e.name, "ready",   {31'd0, issue_ready},  {31'd0, mon_e.rdy});
        cmp(mon_e.name, "pending", pending,               mon_e.pend);
        cmp(mon_e.name, "busy",    {26'd0, busy_count},   {26'd0, mon_e.busy});
        cmp(mon_e.name, "stall",   {16'd0, stall_cycles}, {16'd0, mon_e.stall});
        cmp(mon_e.name, "err",     {31'd0, err_spurious}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic expect_all(input string name, input logic rdy, input logic [31:0] p,
                            input logic [5:0] b, input logic [15:0] s, input logic e);
    exp_t x;
    x.cyc = cyc; x.name = name; x.rdy = rdy; x.pend = p; x.busy = b; x.stall = s; x.err = e;
    q.push_back(x);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic wr,
                       input logic [4:0] dest, input logic wbv, input logic [4:0] wbd,
                       input logic fl);
    @(posedge clk);
    #1;
    issue_valid = v;  issue_rs = rs; issue_use_rs = urs; issue_rt = rt; issue_use_rt = urt;
    issue_wr = wr;    issue_dest = dest; wb_valid = wbv; wb_dest = wbd; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  localparam logic [31:0] P5  = 32'h0000_0020;
  localparam logic [31:0] P7  = 32'h0000_0080;
  localparam logic [31:0] P10 = 32'h0000_0400;

  initial begin
    logic [31:0] fill;
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_rs = 5'd0; issue_rt = 5'd0; issue_use_rs = 1'b0;
    issue_use_rt = 1'b0; issue_wr = 1'b0; issue_dest = 5'd0; wb_valid = 1'b0;
    wb_dest = 5'd0; flush = 1'b0;

    idle(); expect_all("reset", 1'b1, 32'd0, 6'd0, 16'd0, 1'b0);
    idle(); rst_n = 1'b1; expect_all("post_reset", 1'b1, 32'd0, 6'd0, 16'd0, 1'b0);

    // RAW stall on r5 until its write-back, released by same-cycle bypass.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
    expect_all("A1_issue_w5", 1'b1, 32'd0, 6'd0, 16'd0, 1'b0);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_all("A2_raw", 1'b0, P5, 6'd1, 16'd0, 1'b0);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_all("A3_raw", 1'b0, P5, 6'd1, 16'd1, 1'b0);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_all("A4_raw", 1'b0, P5, 6'd1, 16'd2, 1'b0);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
    expect_all("A5_bypass", 1'b1, P5, 6'd1, 16'd3, 1'b0);
    idle(); expect_all("A6_cleared", 1'b1, 32'd0, 6'd0, 16'd3, 1'b0);

    // Register 0 is never tracked.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_all("B1_w0", 1'b1, 32'd0, 6'd0, 16'd3, 1'b0);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_all("B2_r0", 1'b1, 32'd0, 6'd0, 16'd3, 1'b0);
    idle(); expect_all("B3_idle", 1'b1, 32'd0, 6'd0, 16'd3, 1'b0);

    // WAW stall on r7, then same-cycle write-back and re-issue of r7.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    expect_all("C1_w7", 1'b1, 32'd0, 6'd0, 16'd3, 1'b0);
    idle(); expect_all("C2_p7", 1'b1, P7, 6'd1, 16'd3, 1'b0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    expect_all("C2b_waw", 1'b0, P7, 6'd1, 16'd3, 1'b0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0);
    expect_all("C3_wb_and_set", 1'b1, P7, 6'd1, 16'd4, 1'b0);
    idle(); expect_all("C4_still_set", 1'b1, P7, 6'd1, 16'd4, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
    expect_all("C5_wb7", 1'b1, P7, 6'd1, 16'd4, 1'b0);
    idle(); expect_all("C6_clear", 1'b1, 32'd0, 6'd0, 16'd4, 1'b0);

    // Fill r1..r31 then flush alongside a write-back and an issue attempt.
    for (int i = 1; i < 32; i++) begin
      fill    = (32'd1 << i) - 32'd1;
      fill[0] = 1'b0;
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, i[4:0], 1'b0, 5'd0, 1'b0);
      expect_all("D_fill", 1'b1, fill, 6'(i - 1), 16'd4, 1'b0);
    end
    idle(); expect_all("D_full", 1'b1, 32'hFFFF_FFFE, 6'd31, 16'd4, 1'b0);
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1);
    expect_all("D_flush", 1'b0, 32'hFFFF_FFFE, 6'd31, 16'd4, 1'b0);
    idle(); expect_all("D_after_flush", 1'b1, 32'd0, 6'd0, 16'd5, 1'b0);

    // Spurious write-back is sticky and survives flush.
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
    expect_all("E1_wb9", 1'b1, 32'd0, 6'd0, 16'd5, 1'b0);
    idle(); expect_all("E2_err", 1'b1, 32'd0, 6'd0, 16'd5, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    expect_all("E3_flush_no_valid", 1'b0, 32'd0, 6'd0, 16'd5, 1'b1);
    idle(); expect_all("E4_err_kept", 1'b1, 32'd0, 6'd0, 16'd5, 1'b1);

    // Long RAW stall on r10 saturates the counter, then async reset.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0);
    expect_all("F1_w10", 1'b1, 32'd0, 6'd0, 16'd5, 1'b1);
    for (int k = 0; k < 70000; k++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      if (k == 0) expect_all("F2_raw_rt", 1'b0, P10, 6'd1, 16'd5, 1'b1);
    end
    drive(1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_all("F3_saturated", 1'b0, P10, 6'd1, 16'hFFFF, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    expect_all("F4_async_reset", 1'b1, 32'd0, 6'd0, 16'd0, 1'b0);
    idle(); expect_all("F5_in_reset", 1'b1, 32'd0, 6'd0, 16'd0, 1'b0);
    idle(); rst_n = 1'b1; expect_all("F6_released", 1'b1, 32'd0, 6'd0, 16'd0, 1'b0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
